// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock/button inputs and reset/status outputs of the reset sequencer
// Signals: mmcm_locked, btn_rst (to sequencer); rst_out_n, state_out[1:0], lock_lost (from sequencer)
interface rst_sequencer_if;
  logic       mmcm_locked;
  logic       btn_rst;
  logic       rst_out_n;
  logic [1:0] state_out;
  logic       lock_lost;
  modport master (output mmcm_locked, output btn_rst, input rst_out_n, input state_out, input lock_lost);
  modport slave (input mmcm_locked, input btn_rst, output rst_out_n, output state_out, output lock_lost);
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: MMCM-lock and debounced push-button driven reset sequencer
// Ports: clk (10 MHz), reset_n (async, active-low), bus.slave: mmcm_locked, btn_rst in;
//        rst_out_n (high only in RUN), state_out (0 WAIT_LOCK, 1 HOLD, 2 RUN), lock_lost (sticky) out
module rst_sequencer #(
  parameter int C_HOLD_CYCLES     = 16,
  parameter int C_DEBOUNCE_CYCLES = 100_000
) (
  input logic            clk,
  input logic            reset_n,
  rst_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_HOLD = 2'd1, S_RUN = 2'd2} state_t;
  localparam logic [23:0] C_HMAX = 24'(C_HOLD_CYCLES - 1);
  localparam logic [23:0] C_DMAX = 24'(C_DEBOUNCE_CYCLES - 1);
  logic [1:0]  r_lock_sync;
  logic [1:0]  r_btn_sync;
  logic [23:0] r_db_cnt;
  logic        r_btn_db;
  logic [23:0] r_hold_cnt;
  logic [23:0] w_hold_nxt;
  state_t      r_state;
  state_t      w_next;
  logic        r_rst_out_n;
  logic        r_lock_lost;
  logic        w_locked_s;
  logic        w_btn_s;
  assign w_locked_s = r_lock_sync[1];
  assign w_btn_s    = r_btn_sync[1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_sync <= '0;
      r_btn_sync  <= '0;
      r_db_cnt    <= '0;
      r_btn_db    <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], bus.mmcm_locked};
      r_btn_sync  <= {r_btn_sync[0], bus.btn_rst};
      if (w_btn_s == r_btn_db) r_db_cnt <= '0;
      else if (r_db_cnt == C_DMAX) begin
        r_btn_db <= w_btn_s;
        r_db_cnt <= '0;
      end else r_db_cnt <= r_db_cnt + 24'd1;
    end
  end
  always_comb begin
    w_next     = r_state;
    w_hold_nxt = r_hold_cnt;
    case (r_state)
      S_WAIT: if (w_locked_s) begin
        w_next     = S_HOLD;
        w_hold_nxt = '0;
      end
      S_HOLD: if (r_btn_db) w_hold_nxt = '0;
        else if (r_hold_cnt == C_HMAX) begin
          w_next     = S_RUN;
          w_hold_nxt = '0;
        end else w_hold_nxt = r_hold_cnt + 24'd1;
      S_RUN: if (r_btn_db) begin
        w_next     = S_HOLD;
        w_hold_nxt = '0;
      end
      default: w_next = S_WAIT;
    endcase
    // Lock loss overrides any button-driven transition on the same cycle.
    if (!w_locked_s) begin
      w_next     = S_WAIT;
      w_hold_nxt = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_WAIT;
      r_hold_cnt  <= '0;
      r_rst_out_n <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hold_cnt  <= w_hold_nxt;
      r_rst_out_n <= w_next == S_RUN;
      r_lock_lost <= r_lock_lost | (w_next == S_WAIT && r_state != S_WAIT);
    end
  end
  assign bus.rst_out_n = r_rst_out_n;
  assign bus.state_out = r_state;
  assign bus.lock_lost = r_lock_lost;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed self-checking bench for rst_sequencer
module tb_rst_sequencer;
  localparam int H = 16;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  rst_sequencer_if bus();
  rst_sequencer #(.C_HOLD_CYCLES(H), .C_DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #50 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic lock_up(input string tag);
    for (int k = 1; k <= H + 3; k++) begin
      step();
      check({tag, "_rst"}, 32'(bus.rst_out_n), 32'(k >= H + 3));
      if (k == 2 || k == 3 || k == H + 2 || k == H + 3)
        check({tag, "_st"}, 32'(bus.state_out), (k < 3) ? 0 : (k < H + 3) ? 1 : 2);
    end
  endtask
  initial begin
    int lv[4] = '{1, 0, 1, 0};
    int ln[4] = '{3, 4, 5, 12};
    bus.mmcm_locked = 1'b0;
    bus.btn_rst = 1'b0;
    repeat (3) step();
    check("rst_rst_out", 32'(bus.rst_out_n), 0);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_lock_lost", 32'(bus.lock_lost), 0);
    check("rst_btn_db", 32'(dut.r_btn_db), 0);
    reset_n = 1'b1;
    repeat (2) step();
    bus.mmcm_locked = 1'b1;
    lock_up("pwr");
    check("pwr_lock_lost", 32'(bus.lock_lost), 0);
    for (int i = 0; i < 4; i++) begin
      bus.btn_rst = lv[i][0];
      for (int k = 0; k < ln[i]; k++) begin
        step();
        check("bounce_rst", 32'(bus.rst_out_n), 1);
        check("bounce_db", 32'(dut.r_btn_db), 0);
      end
    end
    bus.btn_rst = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      if (k == 41) bus.btn_rst = 1'b0;
      step();
      check("press_rst", 32'(bus.rst_out_n), 32'(k < 11 || k >= 66));
      check("press_db", 32'(dut.r_btn_db), 32'(k >= 10 && k < 50));
      if (k == 11) check("press_st", 32'(bus.state_out), 1);
    end
    bus.mmcm_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("loss_rst", 32'(bus.rst_out_n), 32'(k < 3));
      check("loss_flag", 32'(bus.lock_lost), 32'(k >= 3));
    end
    check("loss_st", 32'(bus.state_out), 0);
    bus.mmcm_locked = 1'b1;
    lock_up("relock");
    check("relock_flag", 32'(bus.lock_lost), 1);
    bus.btn_rst = 1'b1;
    repeat (15) step();
    check("hold_st", 32'(bus.state_out), 1);
    #20;
    reset_n = 1'b0;
    bus.btn_rst = 1'b0;
    #1;
    check("async_rst", 32'(bus.rst_out_n), 0);
    check("async_st", 32'(bus.state_out), 0);
    check("async_flag", 32'(bus.lock_lost), 0);
    repeat (2) step();
    reset_n = 1'b1;
    lock_up("rstrel");
    check("rstrel_flag", 32'(bus.lock_lost), 0);
    bus.btn_rst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 8) bus.mmcm_locked = 1'b0;
      if (k == 10) begin
        check("simul_pre_st", 32'(bus.state_out), 2);
        check("simul_pre_db", 32'(dut.r_btn_db), 1);
        check("simul_pre_flag", 32'(bus.lock_lost), 0);
      end
    end
    check("simul_st", 32'(bus.state_out), 0);
    check("simul_flag", 32'(bus.lock_lost), 1);
    check("simul_rst", 32'(bus.rst_out_n), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
